// File: rtl/eit_drive_sequencer.sv
// EIT current-injection frame sequencer: steps source/sink pairs over N_ELEC electrodes,
// settles, then handshakes with acquisition. Optional handshake timeout: MEAS_TIMEOUT_EN.
module eit_drive_sequencer #(
  parameter int N_ELEC         = 16,
  parameter int DAC_W          = 16,
  parameter int SETTLE_W       = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int EW            = $clog2(N_ELEC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_frame,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [EW-1:0]       skip,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [DAC_W-1:0]    dac_amp,
  input  logic                meas_ack,
  output logic [EW-1:0]       src_sel,
  output logic [EW-1:0]       sink_sel,
  output logic [DAC_W-1:0]    dac_val,
  output logic                drive_en,
  output logic                meas_req,
  output logic [EW-1:0]       step_idx,
  output logic                step_done,
  output logic                frame_done,
  output logic                busy,
  output logic                cfg_err,
  output logic                meas_err,
  output logic [1:0]          dbg_state
);

  // Handshake: meas_req rises when settling ends and stays high until the edge
  // on which meas_ack is sampled high; meas_ack is ignored outside MEASURE.
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, MEASURE = 2'd2} state_e;

  state_e state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [EW-1:0]       skip_q, skip_d;
  logic [SETTLE_W-1:0] settle_q, settle_d, cnt_q, cnt_d;
  logic [EW-1:0]       src_q, src_d, sink_q, sink_d, step_q, step_d;
  logic [DAC_W-1:0]    dac_q, dac_d;
  logic drive_q, drive_d, req_q, req_d, busy_q, busy_d;
  logic step_done_q, step_done_d, frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;
  logic step_end;
  logic [EW-1:0] step_next;

  assign step_next = step_q + EW'(1);

  function automatic logic [EW-1:0] sink_of(input logic [1:0] m, input logic [EW-1:0] k,
                                            input logic [EW-1:0] s);
    case (m)
      2'd1:    sink_of = s + EW'(N_ELEC / 2);
      2'd2:    sink_of = s + EW'(1) + k;
      default: sink_of = s + EW'(1);
    endcase
  endfunction

`ifdef MEAS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_q, to_d;
  logic meas_err_q, meas_err_d;
  assign meas_err = meas_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign meas_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    skip_d       = skip_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    src_d        = src_q;
    sink_d       = sink_q;
    step_d       = step_q;
    dac_d        = dac_q;
    drive_d      = drive_q;
    req_d        = req_q;
    busy_d       = busy_q;
    step_done_d  = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    step_end     = 1'b0;
`ifdef MEAS_TIMEOUT_EN
    to_d         = to_q;
    meas_err_d   = meas_err_q;
`endif
    if (abort) begin
      state_d = IDLE;
      src_d   = '0;
      sink_d  = '0;
      step_d  = '0;
      dac_d   = '0;
      drive_d = 1'b0;
      req_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_frame) begin
            // Skip of N_ELEC-1 would make sink equal source on every step.
            if (mode == 2'd2 && skip == EW'(N_ELEC - 1)) begin
              cfg_err_d = 1'b1;
            end else begin
              mode_d   = mode;
              skip_d   = skip;
              settle_d = settle_cycles;
              step_d   = '0;
              src_d    = '0;
              sink_d   = sink_of(mode, skip, '0);
              dac_d    = dac_amp;
              drive_d  = 1'b1;
              busy_d   = 1'b1;
              cnt_d    = settle_cycles;
              state_d  = SETTLE;
`ifdef MEAS_TIMEOUT_EN
              meas_err_d = 1'b0;
`endif
            end
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            req_d   = 1'b1;
            state_d = MEASURE;
`ifdef MEAS_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        MEASURE: begin
          step_end = meas_ack;
`ifdef MEAS_TIMEOUT_EN
          if (!meas_ack) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
              step_end   = 1'b1;
              meas_err_d = 1'b1;
            end else begin
              to_d = to_q + TO_W'(1);
            end
          end
`endif
          if (step_end) begin
            req_d       = 1'b0;
            step_done_d = 1'b1;
            if (step_q == EW'(N_ELEC - 1)) begin
              frame_done_d = 1'b1;
              drive_d      = 1'b0;
              dac_d        = '0;
              busy_d       = 1'b0;
              src_d        = '0;
              sink_d       = '0;
              step_d       = '0;
              state_d      = IDLE;
            end else begin
              step_d  = step_next;
              src_d   = step_next;
              sink_d  = sink_of(mode_q, skip_q, step_next);
              cnt_d   = settle_q;
              state_d = SETTLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      skip_q       <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      src_q        <= '0;
      sink_q       <= '0;
      step_q       <= '0;
      dac_q        <= '0;
      drive_q      <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
      to_q         <= '0;
      meas_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      skip_q       <= skip_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      sink_q       <= sink_d;
      step_q       <= step_d;
      dac_q        <= dac_d;
      drive_q      <= drive_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      step_done_q  <= step_done_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef MEAS_TIMEOUT_EN
      to_q         <= to_d;
      meas_err_q   <= meas_err_d;
`endif
    end
  end

  assign src_sel    = src_q;
  assign sink_sel   = sink_q;
  assign dac_val    = dac_q;
  assign drive_en   = drive_q;
  assign meas_req   = req_q;
  assign step_idx   = step_q;
  assign step_done  = step_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_eit_drive_sequencer.sv
// Bench for eit_drive_sequencer: table-driven and random frames against a pattern model,
// plus abort, mid-frame reset and (with MEAS_TIMEOUT_EN) handshake timeout sequences.
module tb_eit_drive_sequencer;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, start_frame, abort, meas_ack;
  logic [1:0]  mode;
  logic [3:0]  skip;
  logic [7:0]  settle_cycles;
  logic [15:0] dac_amp;
  logic [3:0]  src_sel, sink_sel, step_idx;
  logic [15:0] dac_val;
  logic        drive_en, meas_req, step_done, frame_done, busy, cfg_err, meas_err;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int sd_cnt = 0;
  int fd_cnt = 0;

  eit_drive_sequencer #(.N_ELEC(N), .DAC_W(16), .SETTLE_W(8), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .abort(abort), .mode(mode),
    .skip(skip), .settle_cycles(settle_cycles), .dac_amp(dac_amp), .meas_ack(meas_ack),
    .src_sel(src_sel), .sink_sel(sink_sel), .dac_val(dac_val), .drive_en(drive_en),
    .meas_req(meas_req), .step_idx(step_idx), .step_done(step_done),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err), .meas_err(meas_err),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      sd_cnt += int'(step_done);
      fd_cnt += int'(frame_done);
    end
  end

  // Scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({src_sel, sink_sel, dac_val, drive_en, meas_req, step_idx, step_done,
                frame_done, busy, cfg_err, meas_err});
  endfunction

  // Reference model: sink electrode from the drive-pattern rule
  function automatic int exp_sink(input int m, input int k, input int s);
    int off;
    off = (m == 1) ? N / 2 : (m == 2) ? 1 + k : 1;
    return (s + off) % N;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      meas_ack    = 1'($urandom_range(0, 1));
      start_frame = 1'($urandom_range(0, 1));
      mode        = 2'($urandom_range(0, 3));
      dac_amp     = 16'($urandom);
      tick();
      n++;
      if (meas_req) ok = 1;
    end
    meas_ack    = 1'b0;
    start_frame = 1'b0;
    check("meas_req seen", 64'(ok), 64'd1);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [3:0] k, input logic [7:0] st,
                           input logic [15:0] amp, input bit reject);
    int n, sd0, fd0, d;
    bit ok, held;
    sd0 = sd_cnt;
    fd0 = fd_cnt;
    mode = m; skip = k; settle_cycles = st; dac_amp = amp; start_frame = 1'b1;
    tick();
    start_frame   = 1'b0;
    mode          = 2'($urandom_range(0, 3));
    skip          = 4'($urandom_range(0, 15));
    settle_cycles = 8'($urandom_range(0, 9));
    dac_amp       = 16'($urandom);
    if (reject) begin
      check("cfg_err pulse", 64'(cfg_err), 64'd1);
      check("busy after reject", 64'({busy, drive_en}), 64'd0);
      tick();
      check("cfg_err width", 64'(cfg_err), 64'd0);
      check("no steps after reject", 64'(sd_cnt - sd0), 64'd0);
      return;
    end
    check("cfg_err on valid", 64'(cfg_err), 64'd0);
    for (int s = 0; s < N; s++) begin
      check($sformatf("step %0d outputs", s),
            64'({busy, drive_en, dac_val, step_idx, src_sel, sink_sel}),
            64'({1'b1, 1'b1, amp, 4'(s), 4'(s), 4'(exp_sink(m, k, s))}));
      wait_req(n, ok);
      check($sformatf("settle latency step %0d", s), 64'(n), 64'(st) + 64'd1);
      d    = $urandom_range(0, 3);
      held = 1;
      for (int i = 0; i < d; i++) begin
        tick();
        if (!meas_req) held = 0;
      end
      check("meas_req held", 64'(held), 64'd1);
      meas_ack    = 1'b1;
      start_frame = (s == N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      meas_ack    = 1'b0;
      start_frame = 1'b0;
      check("step_done/meas_req after ack", 64'({step_done, meas_req}), 64'b10);
      if (s == N - 1) begin
        check("frame_done", 64'(frame_done), 64'd1);
        check("idle after frame",
              64'({busy, drive_en, dac_val, step_idx, src_sel, sink_sel}), 64'd0);
      end
    end
    tick();
    check("post-frame idle", 64'({frame_done, step_done, busy, drive_en}), 64'd0);
    check("step_done pulses", 64'(sd_cnt - sd0), 64'(N));
    check("frame_done pulses", 64'(fd_cnt - fd0), 64'd1);
  endtask

  task automatic goto_measure(input int target);
    int n;
    bit ok;
    mode = 2'd0; skip = 4'd0; settle_cycles = 8'd1; dac_amp = 16'h0F0F; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    for (int s = 0; s <= target; s++) begin
      wait_req(n, ok);
      if (s < target) begin
        meas_ack = 1'b1;
        tick();
        meas_ack = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [3:0]  k;
    logic [7:0]  st;
    logic [15:0] amp;
    bit          reject;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int sd0, n;
    bit ok, done;
    vecs[0] = '{2'd0, 4'd0,  8'd3, 16'h1234, 1'b0};
    vecs[1] = '{2'd1, 4'd5,  8'd0, 16'hABCD, 1'b0};
    vecs[2] = '{2'd2, 4'd2,  8'd1, 16'h5555, 1'b0};
    vecs[3] = '{2'd2, 4'd15, 8'd2, 16'h7777, 1'b1};
    vecs[4] = '{2'd3, 4'd9,  8'd2, 16'hFFFF, 1'b0};
    vecs[5] = '{2'd2, 4'd0,  8'd5, 16'h0001, 1'b0};
    vecs[6] = '{2'd2, 4'd14, 8'd0, 16'h8000, 1'b0};
    vecs[7] = '{2'd1, 4'd15, 8'd4, 16'h00FF, 1'b0};

    rst = 1'b1; start_frame = 1'b0; abort = 1'b0; meas_ack = 1'b0;
    mode = 2'd0; skip = 4'd0; settle_cycles = 8'd0; dac_amp = 16'd0;
    tick();
    tick();
    check("reset outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();
    check("idle after reset", all_outs(), 64'd0);

    foreach (vecs[i]) run_frame(vecs[i].m, vecs[i].k, vecs[i].st, vecs[i].amp, vecs[i].reject);

    for (int i = 0; i < 6; i++) begin
      logic [1:0] rm;
      logic [3:0] rk;
      rm = 2'($urandom_range(0, 3));
      rk = 4'($urandom_range(0, 15));
      run_frame(rm, rk, 8'($urandom_range(0, 6)), 16'($urandom), (rm == 2'd2 && rk == 4'd15));
    end

    // Abort on the ack edge of step 7, with start_frame also raised
    goto_measure(7);
    check("at step 7", 64'({step_idx, meas_req}), 64'({4'd7, 1'b1}));
    sd0 = sd_cnt;
    meas_ack = 1'b1; abort = 1'b1; start_frame = 1'b1;
    tick();
    meas_ack = 1'b0; abort = 1'b0; start_frame = 1'b0;
    check("abort on ack edge", all_outs(), 64'd0);
    tick();
    check("no step_done on abort", 64'(sd_cnt - sd0), 64'd0);

    // Abort during settle, then abort beats start_frame in IDLE
    mode = 2'd1; settle_cycles = 8'd5; dac_amp = 16'h2222; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    check("busy before abort", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    check("abort in settle", all_outs(), 64'd0);
    start_frame = 1'b1;
    tick();
    abort = 1'b0; start_frame = 1'b0;
    check("abort beats start", 64'({busy, drive_en}), 64'd0);

    // Asynchronous reset while in MEASURE of step 5
    goto_measure(5);
    check("at step 5", 64'({step_idx, meas_req}), 64'({4'd5, 1'b1}));
    #2 rst = 1'b1;
    #1 check("async reset mid-frame", all_outs(), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(2'd0, 4'd0, 8'd3, 16'h1234, 1'b0);

`ifdef MEAS_TIMEOUT_EN
    goto_measure(2);
    n = 0;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      n++;
      if (step_done) done = 1;
    end
    check("timeout step_done", 64'(done), 64'd1);
    check("timeout latency", 64'(n), 64'd10);
    check("timeout flags", 64'({meas_err, meas_req, step_idx}), 64'({1'b1, 1'b0, 4'd3}));
    for (int s = 3; s < N; s++) begin
      wait_req(n, ok);
      meas_ack = 1'b1;
      tick();
      meas_ack = 1'b0;
    end
    check("frame after timeout", 64'({frame_done, meas_err}), 64'b11);
    tick();
    check("meas_err sticky", 64'(meas_err), 64'd1);
    mode = 2'd0; settle_cycles = 8'd2; start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    check("meas_err cleared by start", 64'({busy, meas_err}), 64'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    check("meas_err tied low", 64'(meas_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
